// File: rtl/alu_pkg.sv
// Shared opcode, status-bit and FSM definitions for the alu_mc multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_NOT = 5'h05;
  localparam logic [4:0] OP_XOR = 5'h06;
  localparam logic [4:0] OP_SHL = 5'h07;
  localparam logic [4:0] OP_SHR = 5'h08;
  localparam logic [4:0] OP_VAL = 5'h09;
  localparam logic [4:0] OP_ADC = 5'h0A;
  localparam logic [4:0] OP_SBB = 5'h0B;
  localparam logic [4:0] OP_MUL = 5'h0C;

  localparam int ST_CARRY  = 0;
  localparam int ST_BORROW = 1;
  localparam int ST_ZERO   = 2;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } alu_state_t;

  // Zero is only reported when the result is clean, i.e. no carry or borrow escaped.
  function automatic logic [2:0] make_status(input logic res_zero, input logic carry,
                                             input logic borrow);
    logic [2:0] st;
    st            = 3'b000;
    st[ST_CARRY]  = carry;
    st[ST_BORROW] = borrow;
    st[ST_ZERO]   = res_zero & ~carry & ~borrow;
    return st;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per product.
// Built only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d;

  // done_o marks the cycle of the final step; product_o already includes that step.
  assign done_o    = run_q && (cnt_q == '0);
  assign product_o = acc_d;

  // Step sequencing: load operands on start, then one shift-add per cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNT_W'(DATA_W - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        cnt_d = cnt_q;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready handshake and a stored carry flag.
// Define ALU_MUL_EN to build the iterative MUL; without it opcode 0C decodes as NOP.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  input  logic [7:0]        param,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        status,
  output logic              cf
);

  logic [DATA_W-1:0]   result_q, result_d;
  logic [2:0]          status_q, status_d;
  logic                cf_q, cf_d;
  logic                out_valid_q, out_valid_d;

  logic                accept_s, busy_s, is_mul_s, mul_done_s;
  logic [2*DATA_W-1:0] mul_prod_s;
  logic [2:0]          mul_status_s, alu_status_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_carry_s, alu_borrow_s, alu_def_s, alu_cf_wr_s;
  logic [DATA_W:0]     arith_s;
  logic [2*DATA_W-1:0] shift_s;
  logic [SHAMT_W-1:0]  shamt_s;

  assign shamt_s  = param[SHAMT_W-1:0];
  assign in_ready = !rst && !busy_s && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;

`ifdef ALU_MUL_EN
  alu_state_t state_q, state_d;

  assign is_mul_s = (opcode == OP_MUL);
  assign busy_s   = (state_q == S_MUL_BUSY);

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (accept_s && is_mul_s),
    .a_i       (operand1),
    .b_i       (operand2),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // FSM next state: park in MUL_BUSY until the multiplier finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_d = S_MUL_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_BUSY: begin
        if (mul_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign busy_s     = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_prod_s = '0;
`endif

  assign mul_status_s = make_status(mul_prod_s[DATA_W-1:0] == '0,
                                    |mul_prod_s[2*DATA_W-1:DATA_W], 1'b0);

  // Single-cycle datapath; arithmetic runs one bit wider to expose carry/borrow.
  always_comb begin
    alu_res_s    = '0;
    alu_carry_s  = 1'b0;
    alu_borrow_s = 1'b0;
    alu_def_s    = 1'b1;
    alu_cf_wr_s  = 1'b0;
    arith_s      = '0;
    shift_s      = '0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        if (opcode == OP_ADC) begin
          arith_s = {1'b0, operand1} + {1'b0, operand2} + {{DATA_W{1'b0}}, cf_q};
        end else begin
          arith_s = {1'b0, operand1} + {1'b0, operand2};
        end
        alu_res_s   = arith_s[DATA_W-1:0];
        alu_carry_s = arith_s[DATA_W];
        alu_cf_wr_s = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        if (opcode == OP_SBB) begin
          arith_s = {1'b0, operand1} - {1'b0, operand2} - {{DATA_W{1'b0}}, cf_q};
        end else begin
          arith_s = {1'b0, operand1} - {1'b0, operand2};
        end
        alu_res_s    = arith_s[DATA_W-1:0];
        alu_borrow_s = arith_s[DATA_W];
        alu_cf_wr_s  = 1'b1;
      end
      OP_AND: alu_res_s = operand1 & operand2;
      OP_OR:  alu_res_s = operand1 | operand2;
      OP_XOR: alu_res_s = operand1 ^ operand2;
      OP_NOT: alu_res_s = ~operand2;
      OP_SHL: begin
        shift_s     = {{DATA_W{1'b0}}, operand1} << shamt_s;
        alu_res_s   = shift_s[DATA_W-1:0];
        alu_carry_s = |shift_s[2*DATA_W-1:DATA_W];
      end
      OP_SHR: begin
        shift_s     = {operand1, {DATA_W{1'b0}}} >> shamt_s;
        alu_res_s   = shift_s[2*DATA_W-1:DATA_W];
        alu_carry_s = |shift_s[DATA_W-1:0];
      end
      OP_VAL: alu_res_s = DATA_W'(param);
      OP_NOP, OP_MUL: alu_def_s = 1'b0;
      default: alu_def_s = 1'b0;
    endcase
  end

  assign alu_status_s = alu_def_s ? make_status(alu_res_s == '0, alu_carry_s, alu_borrow_s)
                                  : 3'b000;

  // Output register next state: pop on out_ready, load on a 1-cycle op or multiply completion.
  always_comb begin
    result_d = result_q;
    status_d = status_q;
    cf_d     = cf_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (mul_done_s) begin
      result_d    = mul_prod_s[DATA_W-1:0];
      status_d    = mul_status_s;
      out_valid_d = 1'b1;
    end else if (accept_s && !is_mul_s) begin
      result_d    = alu_res_s;
      status_d    = alu_status_s;
      out_valid_d = 1'b1;
      if (alu_cf_wr_s) begin
        cf_d = alu_carry_s | alu_borrow_s;
      end else begin
        cf_d = cf_q;
      end
    end else begin
      result_d = result_q;
      status_d = status_q;
    end
  end

  // Output and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      status_q    <= 3'b000;
      cf_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      status_q    <= status_d;
      cf_q        <= cf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign status    = status_q;
  assign cf        = cf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus randomized ops against a behavioural model.
module tb_alu_mc;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, cf;
  logic [4:0]   opcode;
  logic [W-1:0] operand1, operand2, result;
  logic [7:0]   param;
  logic [2:0]   status;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_cf;

  always #5 clk = ~clk;

  alu_mc #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .operand1(operand1), .operand2(operand2), .param(param), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .status(status), .cf(cf)
  );

  // Behavioural model with plain integers: returns {cf_next, status[2:0], result[7:0]}.
  function automatic logic [11:0] ref_op(input int op, input int a, input int b, input int p,
                                         input logic cin);
    int   r, mask, n;
    bit   c, bw, def;
    logic cf_n;
    mask = (1 << W) - 1;
    n = p % W;
    r = 0; c = 1'b0; bw = 1'b0; def = 1'b1; cf_n = cin;
    case (op)
      1:  begin r = a + b; c = (r > mask); cf_n = c; end
      2:  begin r = a - b; bw = (r < 0); cf_n = bw; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = ~b;
      6:  r = a ^ b;
      7:  begin r = a << n; c = ((r >> W) != 0); end
      8:  begin r = a >> n; c = ((a % (1 << n)) != 0); end
      9:  r = p;
      10: begin r = a + b + int'(cin); c = (r > mask); cf_n = c; end
      11: begin r = a - b - int'(cin); bw = (r < 0); cf_n = bw; end
      12: if (MUL_ON) begin r = a * b; c = ((r >> W) != 0); end else def = 1'b0;
      default: def = 1'b0;
    endcase
    if (!def) r = 0;
    r = r & mask;
    return {cf_n, (def && (r == 0) && !c && !bw), bw, c, r[W-1:0]};
  endfunction

  task automatic send(input int op, input int a, input int b, input int p);
    opcode = op[4:0]; operand1 = a[W-1:0]; operand2 = b[W-1:0]; param = p[7:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 5'h01; operand1 = 8'hFF; operand2 = 8'h02; param = 8'h00;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (result !== 8'h00 || status !== 3'b000) begin n_err++; $display("FAIL rst_result: got %h/%b expected 00/000", result, status); end
    n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL rst_cf: got %b expected 0", cf); end
    rst = 1'b0; exp_cf = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_arith;
    int ops[5] = '{1, 10, 2, 11, 2};
    int as[5]  = '{255, 0, 14, 16, 126};
    int bs[5]  = '{2, 0, 15, 1, 126};
    logic [11:0] e;
    for (int i = 0; i < 5; i++) begin
      e = ref_op(ops[i], as[i], bs[i], 0, exp_cf);
      send(ops[i], as[i], bs[i], 0);
      exp_cf = e[11];
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arith%0d_valid: got %b expected 1", i, out_valid); end
      n_cmp++; if (result !== e[7:0] || status !== e[10:8]) begin n_err++; $display("FAIL arith%0d: got %h/%b expected %h/%b", i, result, status, e[7:0], e[10:8]); end
      n_cmp++; if (cf !== e[11]) begin n_err++; $display("FAIL arith%0d_cf: got %b expected %b", i, cf, e[11]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int ops[4] = '{3, 4, 5, 6};
    int as[4]  = '{8'hCC, 8'hF0, 8'h00, 8'hF0};
    int bs[4]  = '{8'h33, 8'h0F, 8'hFF, 8'hF0};
    logic [11:0] e[4];
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) e[i] = ref_op(ops[i], as[i], bs[i], 0, exp_cf);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        opcode = ops[i][4:0]; operand1 = as[i][W-1:0]; operand2 = bs[i][W-1:0]; param = 8'h00;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        n_cmp++; if (out_valid !== 1'b1 || result !== e[i-1][7:0] || status !== e[i-1][10:8]) begin
          n_err++; $display("FAIL b2b%0d: got v=%b %h/%b expected v=1 %h/%b", i-1, out_valid, result, status, e[i-1][7:0], e[i-1][10:8]);
        end
      end
      if (i < 4) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_ready: got %b expected 1", i, in_ready); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    logic [11:0] e, e2;
    out_ready = 1'b0;
    e = ref_op(1, 4, 6, 0, exp_cf);
    send(1, 4, 6, 0);
    exp_cf = e[11];
    opcode = 5'h09; param = 8'h3C; in_valid = 1'b1;
    e2 = ref_op(9, 0, 0, 8'h3C, exp_cf);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || result !== e[7:0] || status !== e[10:8]) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b %h/%b expected v=1 %h/%b", i, out_valid, result, status, e[7:0], e[10:8]);
      end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || result !== e2[7:0] || status !== e2[10:8]) begin
      n_err++; $display("FAIL stall_next: got v=%b %h/%b expected v=1 %h/%b", out_valid, result, status, e2[7:0], e2[10:8]);
    end
    exp_cf = e2[11];
    @(negedge clk);
  endtask

  task automatic test_shift_val;
    int ops[3] = '{7, 8, 9};
    int as[3]  = '{8'hF0, 8'h01, 8'h00};
    int ps[3]  = '{2, 1, 8'h5A};
    logic [11:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = ref_op(ops[i], as[i], 0, ps[i], exp_cf);
      send(ops[i], as[i], 0, ps[i]);
      exp_cf = e[11];
      n_cmp++; if (out_valid !== 1'b1 || result !== e[7:0] || status !== e[10:8]) begin
        n_err++; $display("FAIL shift%0d: got v=%b %h/%b expected v=1 %h/%b", i, out_valid, result, status, e[7:0], e[10:8]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul;
    int as[2] = '{15, 16};
    int bs[2] = '{17, 16};
    logic [11:0] e;
    out_ready = 1'b1;
`ifdef ALU_MUL_EN
    for (int i = 0; i < 2; i++) begin
      e = ref_op(12, as[i], bs[i], 0, exp_cf);
      send(12, as[i], bs[i], 0);
      for (int c = 0; c < W; c++) begin
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_err++; $display("FAIL mul%0d_busy%0d: got ready=%b valid=%b expected 0/0", i, c, in_ready, out_valid);
        end
        @(negedge clk);
      end
      n_cmp++; if (out_valid !== 1'b1 || result !== e[7:0] || status !== e[10:8]) begin
        n_err++; $display("FAIL mul%0d: got v=%b %h/%b expected v=1 %h/%b", i, out_valid, result, status, e[7:0], e[10:8]);
      end
      n_cmp++; if (cf !== exp_cf) begin n_err++; $display("FAIL mul%0d_cf: got %b expected %b", i, cf, exp_cf); end
      @(negedge clk);
    end
    send(12, 3, 5, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_cf = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_abort%0d: got valid=%b expected 0", c, out_valid); end
      @(negedge clk);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_abort_idle: got ready=%b expected 1", in_ready); end
`else
    for (int i = 0; i < 2; i++) begin
      e = ref_op(12, as[i], bs[i], 0, exp_cf);
      send(12, as[i], bs[i], 0);
      n_cmp++; if (out_valid !== 1'b1 || result !== e[7:0] || status !== e[10:8]) begin
        n_err++; $display("FAIL mul_nop%0d: got v=%b %h/%b expected v=1 %h/%b", i, out_valid, result, status, e[7:0], e[10:8]);
      end
      n_cmp++; if (cf !== exp_cf) begin n_err++; $display("FAIL mul_nop%0d_cf: got %b expected %b", i, cf, exp_cf); end
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_random;
    int op, a, b, p, cyc;
    logic [11:0] e;
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 31)) : int'($urandom_range(0, 12));
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); p = int'($urandom_range(0, 255));
      e = ref_op(op, a, b, p, exp_cf);
      opcode = op[4:0]; operand1 = a[W-1:0]; operand2 = b[W-1:0]; param = p[7:0];
      in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_ready: got %b expected 1", k, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL rnd%0d_timeout: op %h got no out_valid expected one", k, op);
      end else if (result !== e[7:0] || status !== e[10:8] || cf !== e[11]) begin
        n_err++; $display("FAIL rnd%0d: op %h a %h b %h p %h got %h/%b cf=%b expected %h/%b cf=%b",
                          k, op, a, b, p, result, status, cf, e[7:0], e[10:8], e[11]);
      end
      exp_cf = e[11];
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_shift_val();
    test_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Registered, multi-cycle successor to the combinational 8-bit CPU ALU, parametrised in data width. It keeps the existing opcode set and 3-bit status encoding. It adds carry-chained ADC/SBB, a stored carry flag, and an iterative MUL. A valid/ready handshake sits on both sides, so the CPU control unit can stall on multi-cycle operations.

Parameters:
DATA_W, 8, operand/result width (>=4)
SHAMT_W, $clog2(DATA_W), number of low param bits used as the shift amount

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  block accepts a request this cycle
opcode  in  5  operation code
operand1  in  DATA_W  first operand
operand2  in  DATA_W  second operand
param  in  8  immediate / shift amount
out_valid  out  1  result/status valid
out_ready  in  1  consumer takes the result
result  out  DATA_W  registered result
status  out  3  [0] carry/overflow, [1] borrow, [2] zero
cf  out  1  stored carry/borrow flag

Behaviour:
- Opcodes, fixed:
  - NOP=00: result 0, status 0
  - ADD=01, SUB=02
  - AND=03, OR=04, XOR=06
  - NOT=05: result = ~operand2
  - SHL=07, SHR=08: shift operand1 by param[SHAMT_W-1:0]
  - VAL=09: result = param, zero-extended or truncated to DATA_W
  - ADC=0A: op1+op2+cf
  - SBB=0B: op1-op2-cf
  - MUL=0C: low DATA_W bits of op1*op2
  - Undefined opcodes behave as NOP.
- Arithmetic is computed at DATA_W+1 bits.
  - status[0]: carry-out for ADD/ADC; any 1 shifted out for SHL/SHR; nonzero high half for MUL.
  - status[1]: borrow for SUB/SBB.
- status[2] = (result==0) && !status[0] && !status[1].
  - 255+1 gives result 0 with status 001, not zero.
  - 0+0 gives status 100.
- cf is updated only when an ADD/SUB/ADC/SBB result is registered: cf <= carry for ADD/ADC, borrow for SUB/SBB. cf is unchanged for all other ops.
- Handshake:
  - in_ready = !rst && state==IDLE && (!out_valid || out_ready).
  - A request is accepted when in_valid && in_ready.
  - out_valid, result and status hold stable until out_valid && out_ready.
  - Accept and pop in the same cycle is legal and gives full single-cycle throughput.
- FSM IDLE/MUL_BUSY:
  - In IDLE, a non-MUL request that is accepted registers result/status next edge, so latency is 1 cycle.
  - In IDLE, an accepted MUL latches the operands and moves to MUL_BUSY with counter = DATA_W-1.
  - MUL_BUSY performs one shift-add step per cycle.
  - When counter reaches 0, MUL_BUSY loads result/status, sets out_valid and returns to IDLE. Latency is DATA_W cycles from accept.
  - in_ready is 0 throughout MUL_BUSY.
- ADC issued directly after ADD sees the cf written on the same edge that registered the ADD result. No hazard.
- Reset:
  - result=0, status=0, cf=0, out_valid=0, state=IDLE.
  - An asserted rst aborts an in-flight MUL with no output.
  - in_ready is 0 while rst=1.

Optional Feature:
ALU_MUL_EN
- Defined: MUL is implemented as described above.
- Undefined:
  - No multiplier logic and no MUL_BUSY state are built.
  - Opcode 0C decodes as NOP (result 0, status 0, 1-cycle latency).

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_NOP..OP_MUL
  - status bit indices ST_CARRY=0, ST_BORROW=1, ST_ZERO=2
  - FSM state encoding
- Sub-module alu_mul_seq is a natural split:
  - iterative shift-add multiplier with start/done
  - produces a 2*DATA_W product
  - instantiated only under ALU_MUL_EN

Test Plan:
- ADD 255+2 with out_ready=1 -> one cycle later out_valid=1, result=1, status=001, cf=1. Then ADC 0+0 -> result=1, status=000, cf=0.
- SUB 14-15 -> result=255, status=010, cf=1. SBB 16-1 follows -> result=14, status=000. SUB 126-126 -> result=0, status=100.
- Back-to-back AND CC&33, OR F0|0F, NOT op2=FF, XOR F0^F0 with in_valid and out_ready held high -> one result per cycle: 00/100, FF/000, 00/100, 00/100.
- out_ready=0 after ADD 4+6 -> result=10 held stable and in_ready=0 for 5 cycles. Raising out_ready pops the result and re-asserts in_ready in the same cycle.
- With ALU_MUL_EN:
  - MUL 15*17 -> in_ready low for 8 cycles, then result=255, status=000.
  - MUL 16*16 -> result=0, status=001.
  - rst pulsed during MUL -> no out_valid, state IDLE.
- SHL F0 by param=2 -> result=C0, status=001. SHR 01 by 1 -> result=0, status=001. VAL param=5A -> result=5A, status=000.
